// File: rtl/fp_pkg.sv
// Shared constants, mantissa bit positions and state encoding for the
// FP normalise/round stage.
package fp_pkg;

  localparam int EXP_W  = 8;
  localparam int FRAC_W = 23;
  localparam int BIAS   = (1 << (EXP_W - 1)) - 1;

  // Internal mantissa layout: carry, hidden, fraction, guard, round, sticky
  localparam int MANT_W      = FRAC_W + 5;
  localparam int MANT_CARRY  = FRAC_W + 4;
  localparam int MANT_HIDDEN = FRAC_W + 3;
  localparam int MANT_LSB    = 3;
  localparam int MANT_G      = 2;
  localparam int MANT_R      = 1;
  localparam int MANT_S      = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_NORM  = 2'd1,
    ST_ROUND = 2'd2,
    ST_OUT   = 2'd3
  } state_t;

  // Positive infinity; the sign bit is substituted on overflow
  localparam logic [EXP_W+FRAC_W:0] POS_INF = {1'b0, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};

endpackage

// File: rtl/fp_rne_round.sv
// Round-to-nearest-even on a normalised (or subnormal-floor) mantissa,
// then exponent encode, overflow saturation and packing. Purely combinational.
module fp_rne_round #(
  parameter int EXP_W  = fp_pkg::EXP_W,
  parameter int FRAC_W = fp_pkg::FRAC_W
) (
  input  logic                    sign,
  input  logic [EXP_W+1:0]        exp_in,
  input  logic [FRAC_W+3:0]       mant,      // hidden..sticky; carry bit is always clear here
  output logic [EXP_W+FRAC_W:0]   result,
  output logic                    overflow,
  output logic                    inexact
);
  import fp_pkg::*;

  localparam logic [EXP_W+1:0] EXP_INC = {{(EXP_W+1){1'b0}}, 1'b1};
  localparam logic [EXP_W+1:0] EXP_MAX = {2'b00, {EXP_W{1'b1}}};

  logic                 inc;
  logic [FRAC_W+1:0]    sum;
  logic                 hidden;
  logic [FRAC_W-1:0]    frac;
  logic [EXP_W+1:0]     exp_r;
  logic [EXP_W+1:0]     enc;

  // Increment, renormalise a rounding carry, encode and saturate
  always_comb begin
    inc = mant[MANT_G] & (mant[MANT_R] | mant[MANT_S] | mant[MANT_LSB]);
    sum = {1'b0, mant[FRAC_W+3:MANT_LSB]} + {{(FRAC_W+1){1'b0}}, inc};
    if (sum[FRAC_W+1]) begin
      // 1.111..1 rounded up to 10.000..0: mantissa becomes 1.000, exponent bumps
      hidden = 1'b1;
      frac   = '0;
      exp_r  = exp_in + EXP_INC;
    end else begin
      hidden = sum[FRAC_W];
      frac   = sum[FRAC_W-1:0];
      exp_r  = exp_in;
    end
    // Without the hidden bit the value is subnormal and encodes with exponent 0
    enc      = hidden ? exp_r : '0;
    inexact  = mant[MANT_G] | mant[MANT_R] | mant[MANT_S];
    overflow = 1'b0;
    result   = {sign, enc[EXP_W-1:0], frac};
    if (enc >= EXP_MAX) begin
      overflow = 1'b1;
      result   = {sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
    end
  end

endmodule

// File: rtl/fp_norm_round.sv
// Post-adder stage: iterative 1-bit normalisation, RNE rounding and
// IEEE-754 packing behind valid/ready handshakes on both sides.
module fp_norm_round #(
  parameter int EXP_W  = fp_pkg::EXP_W,
  parameter int FRAC_W = fp_pkg::FRAC_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_sign,
  input  logic [EXP_W:0]         in_exp,
  input  logic [FRAC_W+4:0]      in_mant,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+FRAC_W:0]  out_result,
  output logic                   out_overflow,
  output logic                   out_inexact
);
  import fp_pkg::*;

  localparam int M_W    = FRAC_W + 5;
  localparam int CARRY  = FRAC_W + 4;
  localparam int HIDDEN = FRAC_W + 3;
  localparam logic [EXP_W+1:0] EXP_ONE = {{(EXP_W+1){1'b0}}, 1'b1};

  state_t                  state_q, state_d;
  logic                    sign_q, sign_d;
  logic [EXP_W+1:0]        exp_q, exp_d;
  logic [M_W-1:0]          mant_q, mant_d;
  logic                    out_valid_q, out_valid_d;
  logic [EXP_W+FRAC_W:0]   out_result_q, out_result_d;
  logic                    out_overflow_q, out_overflow_d;
  logic                    out_inexact_q, out_inexact_d;

  logic [EXP_W+FRAC_W:0]   rnd_result;
  logic                    rnd_overflow;
  logic                    rnd_inexact;

  fp_rne_round #(.EXP_W(EXP_W), .FRAC_W(FRAC_W)) u_round (
    .sign     (sign_q),
    .exp_in   (exp_q),
    .mant     (mant_q[HIDDEN:0]),
    .result   (rnd_result),
    .overflow (rnd_overflow),
    .inexact  (rnd_inexact)
  );

  assign in_ready     = (state_q == ST_IDLE);
  assign out_valid    = out_valid_q;
  assign out_result   = out_result_q;
  assign out_overflow = out_overflow_q;
  assign out_inexact  = out_inexact_q;

  // Next-state logic: capture, one normalisation step per cycle, round, hand off
  always_comb begin
    state_d        = state_q;
    sign_d         = sign_q;
    exp_d          = exp_q;
    mant_d         = mant_q;
    out_valid_d    = out_valid_q;
    out_result_d   = out_result_q;
    out_overflow_d = out_overflow_q;
    out_inexact_d  = out_inexact_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          sign_d = in_sign;
          exp_d  = {1'b0, in_exp};
          mant_d = in_mant;
          if (in_mant == '0) begin
            // Exact zero skips normalisation entirely
            out_result_d   = {in_sign, {(EXP_W+FRAC_W){1'b0}}};
            out_overflow_d = 1'b0;
            out_inexact_d  = 1'b0;
            out_valid_d    = 1'b1;
            state_d        = ST_OUT;
          end else begin
            state_d = ST_NORM;
          end
        end
      end
      ST_NORM: begin
        if (mant_q[CARRY]) begin
          // Fold the dropped round bit into sticky on the way out
          mant_d  = {1'b0, mant_q[M_W-1:2], mant_q[MANT_R] | mant_q[MANT_S]};
          exp_d   = exp_q + EXP_ONE;
          state_d = ST_ROUND;
        end else if (!mant_q[HIDDEN] && (exp_q > EXP_ONE)) begin
          mant_d = {mant_q[M_W-2:0], 1'b0};
          exp_d  = exp_q - EXP_ONE;
        end else begin
          state_d = ST_ROUND;
        end
      end
      ST_ROUND: begin
        out_result_d   = rnd_result;
        out_overflow_d = rnd_overflow;
        out_inexact_d  = rnd_inexact;
        out_valid_d    = 1'b1;
        state_d        = ST_OUT;
      end
      ST_OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      sign_q         <= 1'b0;
      exp_q          <= '0;
      mant_q         <= '0;
      out_valid_q    <= 1'b0;
      out_result_q   <= '0;
      out_overflow_q <= 1'b0;
      out_inexact_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      sign_q         <= sign_d;
      exp_q          <= exp_d;
      mant_q         <= mant_d;
      out_valid_q    <= out_valid_d;
      out_result_q   <= out_result_d;
      out_overflow_q <= out_overflow_d;
      out_inexact_q  <= out_inexact_d;
    end
  end

endmodule
